uart_packet_rx_param: RTL and testbench

Parametrised framed-packet receiver between the UART byte receiver and the register/command layer. It hunts for a sync byte, then captures address, length and a variable-length payload of up to `PAYLOAD_BYTES` bytes, and checks a CRC-8 trailer. It publishes a packet only after the CRC passes, and flags length, CRC and (optionally) inter-byte timeout errors. Successor to the fixed 10-byte/7-bit-address receiver: it adds a wider address, configurable depth, length validation, shadowed outputs, error reporting and a timeout.

---
 rtl/uart_packet_rx_param.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_packet_rx_param.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_packet_rx_param.sv
// rtl/uart_packet_rx_param.sv - framed packet receiver with CRC-8 check; define UART_RX_TIMEOUT_EN for inter-byte timeout
module uart_packet_rx_param #(
    parameter int           PAYLOAD_BYTES  = 10,
    parameter int           ADDR_BITS      = 7,
    parameter logic [7:0]   SYNC_BYTE      = 8'h8F,
    parameter logic [15:0]  TIMEOUT_CYCLES = 16'd50000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 uart_rx_data,
    input  logic                       uart_rx_val,
    input  logic                       uartDisabled,
    output logic [ADDR_BITS-1:0]       rx_address,
    output logic [PAYLOAD_BYTES*8-1:0] rx_data,
    output logic [7:0]                 rx_len,
    output logic                       rx_data_val,
    output logic                       rx_crc_err,
    output logic                       rx_len_err,
    output logic                       rx_timeout,
    output logic [7:0]                 rx_err_count
);

    localparam int         DW      = PAYLOAD_BYTES * 8;
    localparam logic [7:0] MAX_LEN = 8'(PAYLOAD_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_COUNT,
        S_DATA,
        S_CRC
    } state_t;

    // CRC-8 SAE J1850 (poly 0x1D, MSB first), one whole byte per call
    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h1D) : (c << 1);
        end
        return c;
    endfunction

    state_t               state_q, state_d;
    logic [7:0]           crc_q, crc_d;
    logic [7:0]           rem_q, rem_d;
    logic [ADDR_BITS-1:0] sh_addr_q, sh_addr_d;
    logic [7:0]           sh_len_q, sh_len_d;
    logic [DW-1:0]        sh_data_q, sh_data_d;
    logic [ADDR_BITS-1:0] rx_address_q, rx_address_d;
    logic [DW-1:0]        rx_data_q, rx_data_d;
    logic [7:0]           rx_len_q, rx_len_d;
    logic                 data_val_q, data_val_d;
    logic                 crc_err_q, crc_err_d;
    logic                 len_err_q, len_err_d;
    logic [7:0]           err_count_q, err_count_d;
    logic                 byte_acc;
    logic                 any_err;
    logic [DW-1:0]        byte_ext;

    assign byte_acc = uart_rx_val & ~uartDisabled;
    assign byte_ext = DW'(uart_rx_data);

`ifdef UART_RX_TIMEOUT_EN
    logic [15:0] idle_q, idle_d;
    logic        timeout_q, timeout_d;
    logic        timeout_hit;

    // Idle counter: counts cycles since the last accepted byte while inside a frame;
    // expiry is decided one cycle early so the pulse lands TIMEOUT_CYCLES after the strobe
    always_comb begin
        idle_d      = idle_q + 16'd1;
        timeout_hit = 1'b0;
        if (state_q == S_IDLE || byte_acc || uartDisabled) begin
            idle_d = 16'd0;
        end else if (idle_q == TIMEOUT_CYCLES - 16'd2) begin
            timeout_hit = 1'b1;
        end
    end

    assign rx_timeout = timeout_q;
`else
    assign rx_timeout = 1'b0;
`endif

    // Frame FSM next-state, shadow capture, publish and error pulses
    always_comb begin
        state_d      = state_q;
        crc_d        = crc_q;
        rem_d        = rem_q;
        sh_addr_d    = sh_addr_q;
        sh_len_d     = sh_len_q;
        sh_data_d    = sh_data_q;
        rx_address_d = rx_address_q;
        rx_data_d    = rx_data_q;
        rx_len_d     = rx_len_q;
        data_val_d   = 1'b0;
        crc_err_d    = 1'b0;
        len_err_d    = 1'b0;
`ifdef UART_RX_TIMEOUT_EN
        timeout_d    = 1'b0;
`endif
        if (uartDisabled) begin
            state_d = S_IDLE;
        end else if (byte_acc) begin
            case (state_q)
                S_IDLE: begin
                    if (uart_rx_data == SYNC_BYTE) begin
                        crc_d   = crc8_update(8'hFF, uart_rx_data);
                        state_d = S_ADDR;
                    end
                end
                S_ADDR: begin
                    sh_addr_d = uart_rx_data[ADDR_BITS-1:0];
                    crc_d     = crc8_update(crc_q, uart_rx_data);
                    state_d   = S_COUNT;
                end
                S_COUNT: begin
                    if (uart_rx_data == 8'd0 || uart_rx_data > MAX_LEN) begin
                        len_err_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        rem_d     = uart_rx_data;
                        sh_len_d  = uart_rx_data;
                        sh_data_d = '0;
                        crc_d     = crc8_update(crc_q, uart_rx_data);
                        state_d   = S_DATA;
                    end
                end
                S_DATA: begin
                    sh_data_d = (sh_data_q << 8) | byte_ext;
                    rem_d     = rem_q - 8'd1;
                    crc_d     = crc8_update(crc_q, uart_rx_data);
                    if (rem_q == 8'd1) begin
                        state_d = S_CRC;
                    end
                end
                S_CRC: begin
                    if (uart_rx_data == crc_q) begin
                        rx_address_d = sh_addr_q;
                        rx_data_d    = sh_data_q;
                        rx_len_d     = sh_len_q;
                        data_val_d   = 1'b1;
                    end else begin
                        crc_err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
`ifdef UART_RX_TIMEOUT_EN
        end else if (timeout_hit) begin
            timeout_d = 1'b1;
            state_d   = S_IDLE;
`endif
        end
        // The running CRC restarts from 0xFF whenever the receiver is (or returns to) hunting
        if (state_d == S_IDLE) begin
            crc_d = 8'hFF;
        end
    end

    // Error counter: one increment per error pulse, saturating
    always_comb begin
        any_err = crc_err_d | len_err_d;
`ifdef UART_RX_TIMEOUT_EN
        any_err = any_err | timeout_d;
`endif
        err_count_d = err_count_q;
        if (any_err && err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    // State and output registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            crc_q        <= 8'hFF;
            rem_q        <= 8'd0;
            sh_addr_q    <= '0;
            sh_len_q     <= 8'd0;
            sh_data_q    <= '0;
            rx_address_q <= '0;
            rx_data_q    <= '0;
            rx_len_q     <= 8'd0;
            data_val_q   <= 1'b0;
            crc_err_q    <= 1'b0;
            len_err_q    <= 1'b0;
            err_count_q  <= 8'd0;
`ifdef UART_RX_TIMEOUT_EN
            idle_q       <= 16'd0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            crc_q        <= crc_d;
            rem_q        <= rem_d;
            sh_addr_q    <= sh_addr_d;
            sh_len_q     <= sh_len_d;
            sh_data_q    <= sh_data_d;
            rx_address_q <= rx_address_d;
            rx_data_q    <= rx_data_d;
            rx_len_q     <= rx_len_d;
            data_val_q   <= data_val_d;
            crc_err_q    <= crc_err_d;
            len_err_q    <= len_err_d;
            err_count_q  <= err_count_d;
`ifdef UART_RX_TIMEOUT_EN
            idle_q       <= idle_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

    assign rx_address   = rx_address_q;
    assign rx_data      = rx_data_q;
    assign rx_len       = rx_len_q;
    assign rx_data_val  = data_val_q;
    assign rx_crc_err   = crc_err_q;
    assign rx_len_err   = len_err_q;
    assign rx_err_count = err_count_q;

endmodule

// File: tb/tb_uart_packet_rx_param.sv
// tb/tb_uart_packet_rx_param.sv - self-checking bench for uart_packet_rx_param
module tb_uart_packet_rx_param;

    localparam int          PB = 10;
    localparam int          AB = 7;
    localparam int          DW = PB * 8;
    localparam logic [15:0] TO = 16'd8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    uart_rx_data = 8'd0;
    logic          uart_rx_val = 1'b0;
    logic          uartDisabled = 1'b0;
    logic [AB-1:0] rx_address;
    logic [DW-1:0] rx_data;
    logic [7:0]    rx_len;
    logic          rx_data_val;
    logic          rx_crc_err;
    logic          rx_len_err;
    logic          rx_timeout;
    logic [7:0]    rx_err_count;

    uart_packet_rx_param #(
        .PAYLOAD_BYTES (PB),
        .ADDR_BITS     (AB),
        .SYNC_BYTE     (8'h8F),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .uart_rx_data(uart_rx_data),
        .uart_rx_val (uart_rx_val),
        .uartDisabled(uartDisabled),
        .rx_address  (rx_address),
        .rx_data     (rx_data),
        .rx_len      (rx_len),
        .rx_data_val (rx_data_val),
        .rx_crc_err  (rx_crc_err),
        .rx_len_err  (rx_len_err),
        .rx_timeout  (rx_timeout),
        .rx_err_count(rx_err_count)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: what the receiver should currently be publishing
    logic [AB-1:0] exp_addr = '0;
    logic [DW-1:0] exp_data = '0;
    logic [7:0]    exp_len  = 8'd0;
    int            exp_err  = 0;

    function automatic logic [3:0] pulses();
        return {rx_data_val, rx_crc_err, rx_len_err, rx_timeout};
    endfunction

    // Bit-serial polynomial division, init 0xFF, no reflection, no final xor
    function automatic logic [7:0] ref_crc(input logic [7:0] b[$]);
        logic [7:0] c;
        logic [7:0] cur;
        logic       fb;
        c = 8'hFF;
        foreach (b[k]) begin
            cur = b[k];
            for (int i = 7; i >= 0; i--) begin
                fb = c[7] ^ cur[i];
                c  = {c[6:0], 1'b0};
                if (fb) c = c ^ 8'h1D;
            end
        end
        return c;
    endfunction

    function automatic void bump_err();
        if (exp_err < 255) exp_err = exp_err + 1;
    endfunction

    // Interprets a complete frame (sync ... deciding byte); returns expected pulse vector
    function automatic logic [3:0] model_apply(input logic [7:0] f[$]);
        logic [7:0] len;
        logic [7:0] body[$];
        logic [7:0] tmp;
        len = f[2];
        if (len == 8'd0 || int'(len) > PB) begin
            bump_err();
            return 4'b0010;
        end
        body = f[0:f.size()-2];
        if (f[f.size()-1] == ref_crc(body)) begin
            tmp      = f[1];
            exp_addr = tmp[AB-1:0];
            exp_len  = len;
            exp_data = '0;
            for (int i = 0; i < int'(len); i++) begin
                exp_data[8*(int'(len)-1-i) +: 8] = f[3+i];
            end
            return 4'b1000;
        end
        bump_err();
        return 4'b0100;
    endfunction

    function automatic void make_frame(input logic [7:0] addr, input logic [7:0] len,
                                       input int bad, output logic [7:0] f[$]);
        logic [7:0] c;
        f = {8'h8F, addr, len};
        if (len == 8'd0 || int'(len) > PB) return;
        for (int i = 0; i < int'(len); i++) f.push_back(8'($urandom));
        c = ref_crc(f);
        if (bad != 0) c = c ^ 8'($urandom_range(1, 255));
        f.push_back(c);
    endfunction

    task automatic send_byte(input logic [7:0] b);
        uart_rx_data = b;
        uart_rx_val  = 1'b1;
        @(posedge clk);
        #1;
        uart_rx_val  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends a frame with random gaps; no pulse may appear before the deciding byte
    task automatic send_frame(input logic [7:0] f[$], input int maxgap);
        foreach (f[i]) begin
            if (i > 0 && maxgap > 0) idle($urandom_range(0, maxgap));
            send_byte(f[i]);
            if (i < f.size() - 1) begin
                n_cmp++;
                if (pulses() !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL midframe_pulse: byte %0d got %b want 0000", i, pulses());
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        n_cmp++;
        if ({rx_address, rx_data, rx_len, rx_err_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got addr=%h data=%h len=%h cnt=%h want all 0",
                     rx_address, rx_data, rx_len, rx_err_count);
        end
        n_cmp++;
        if (pulses() !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_pulses: got %b want 0000", pulses());
        end
    endtask

    task automatic test_good_frame();
        logic [7:0] f[$];
        logic [3:0] ep;
        f = {8'h8F, 8'h05, 8'h02, 8'hAA, 8'h55};
        f.push_back(ref_crc(f));
        send_frame(f, 0);
        ep = model_apply(f);
        n_cmp++;
        if (pulses() !== ep) begin
            n_fail++;
            $display("FAIL good_pulse: got %b want %b", pulses(), ep);
        end
        n_cmp++;
        if (rx_address !== 7'd5 || rx_len !== 8'd2 || rx_data !== 80'hAA55) begin
            n_fail++;
            $display("FAIL good_outputs: got addr=%h len=%h data=%h want 05 02 aa55",
                     rx_address, rx_len, rx_data);
        end
        idle(1);
        n_cmp++;
        if (pulses() !== 4'b0000) begin
            n_fail++;
            $display("FAIL good_pulse_width: got %b want 0000", pulses());
        end
    endtask

    task automatic test_crc_error();
        logic [7:0] f[$];
        logic [3:0] ep;
        f = {8'h8F, 8'h05, 8'h02, 8'hAA, 8'h55};
        f.push_back(ref_crc(f) ^ 8'h01);
        send_frame(f, 0);
        ep = model_apply(f);
        n_cmp++;
        if (pulses() !== ep) begin
            n_fail++;
            $display("FAIL crc_err_pulse: got %b want %b", pulses(), ep);
        end
        n_cmp++;
        if (rx_address !== 7'd5 || rx_len !== 8'd2 || rx_data !== 80'hAA55 || rx_err_count !== 8'd1) begin
            n_fail++;
            $display("FAIL crc_err_hold: got addr=%h len=%h data=%h cnt=%0d want 05 02 aa55 1",
                     rx_address, rx_len, rx_data, rx_err_count);
        end
    endtask

    task automatic test_len_error();
        logic [7:0] f[$];
        logic [7:0] lens[2];
        logic [3:0] ep;
        lens[0] = 8'h00;
        lens[1] = 8'(PB + 1);
        foreach (lens[k]) begin
            make_frame(8'h05, lens[k], 0, f);
            send_frame(f, 0);
            ep = model_apply(f);
            n_cmp++;
            if (pulses() !== ep || rx_err_count !== 8'(exp_err)) begin
                n_fail++;
                $display("FAIL len_err_%0d: got pulses=%b cnt=%0d want %b %0d",
                         k, pulses(), rx_err_count, ep, exp_err);
            end
        end
        f = {8'h8F, 8'h01, 8'h01, 8'hFF};
        f.push_back(ref_crc(f));
        send_frame(f, 0);
        ep = model_apply(f);
        n_cmp++;
        if (pulses() !== 4'b1000 || rx_data !== 80'hFF || rx_len !== 8'd1 || rx_address !== 7'd1) begin
            n_fail++;
            $display("FAIL len_err_recover: got pulses=%b data=%h len=%h addr=%h want 1000 ff 01 01",
                     pulses(), rx_data, rx_len, rx_address);
        end
    endtask

    task automatic test_random();
        logic [7:0] f[$];
        logic [7:0] junk;
        logic [7:0] len;
        logic [3:0] ep;
        int         kind;
        for (int it = 0; it < 60; it++) begin
            repeat ($urandom_range(0, 2)) begin
                do junk = 8'($urandom); while (junk == 8'h8F);
                send_byte(junk);
            end
            kind = $urandom_range(0, 9);
            if (kind < 7)       len = 8'($urandom_range(1, PB));
            else if (kind == 7) len = 8'($urandom_range(1, PB));
            else if (kind == 8) len = 8'h00;
            else                len = 8'($urandom_range(PB + 1, 255));
            make_frame(8'($urandom), len, (kind == 7) ? 1 : 0, f);
            send_frame(f, 2);
            ep = model_apply(f);
            n_cmp++;
            if (pulses() !== ep) begin
                n_fail++;
                $display("FAIL rand_pulse[%0d]: got %b want %b", it, pulses(), ep);
            end
            n_cmp++;
            if (rx_address !== exp_addr || rx_len !== exp_len || rx_data !== exp_data ||
                rx_err_count !== 8'(exp_err)) begin
                n_fail++;
                $display("FAIL rand_out[%0d]: got %h %h %h %0d want %h %h %h %0d", it,
                         rx_address, rx_len, rx_data, rx_err_count,
                         exp_addr, exp_len, exp_data, exp_err);
            end
        end
    endtask

    task automatic test_disable();
        logic [7:0] f[$];
        logic [3:0] ep;
        bit         seen;
        f = {8'h8F, 8'h13, 8'h04, 8'h11, 8'h22};
        foreach (f[i]) send_byte(f[i]);
        uartDisabled = 1'b1;
        send_byte(8'h33);
        uartDisabled = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (pulses() !== 4'b0000) seen = 1'b1;
            idle(1);
        end
        n_cmp++;
        if (seen || rx_err_count !== 8'(exp_err)) begin
            n_fail++;
            $display("FAIL disable_abort: got pulse_seen=%0d cnt=%0d want 0 %0d", seen, rx_err_count, exp_err);
        end
        uartDisabled = 1'b1;
        send_byte(8'h8F);
        uartDisabled = 1'b0;
        f = {8'h8F, 8'h02, 8'h01, 8'h33};
        f.push_back(ref_crc(f));
        send_frame(f, 0);
        ep = model_apply(f);
        n_cmp++;
        if (pulses() !== ep || rx_address !== 7'd2 || rx_data !== 80'h33 || rx_len !== 8'd1) begin
            n_fail++;
            $display("FAIL disable_then_good: got pulses=%b addr=%h data=%h len=%h want %b 02 33 01",
                     pulses(), rx_address, rx_data, rx_len, ep);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] f[$];
        logic [3:0] ep;
        f = {8'h8F, 8'h03, 8'h03, 8'h44, 8'h55, 8'h66};
        f.push_back(ref_crc(f));
`ifdef UART_RX_TIMEOUT_EN
        send_byte(8'h8F);
        send_byte(8'h03);
        for (int k = 1; k <= int'(TO) - 1; k++) begin
            idle(1);
            n_cmp++;
            if (pulses() !== ((k == int'(TO) - 1) ? 4'b0001 : 4'b0000)) begin
                n_fail++;
                $display("FAIL timeout_cycle%0d: got %b", k + 1, pulses());
            end
        end
        bump_err();
        n_cmp++;
        if (rx_err_count !== 8'(exp_err)) begin
            n_fail++;
            $display("FAIL timeout_count: got %0d want %0d", rx_err_count, exp_err);
        end
        send_byte(f[0]);
        send_byte(f[1]);
        idle(int'(TO) - 2);
        send_byte(f[2]);
        n_cmp++;
        if (pulses() !== 4'b0000) begin
            n_fail++;
            $display("FAIL timeout_byte_wins: got %b want 0000", pulses());
        end
        for (int i = 3; i < f.size(); i++) send_byte(f[i]);
`else
        send_byte(f[0]);
        send_byte(f[1]);
        for (int k = 0; k < 40; k++) begin
            idle(1);
            n_cmp++;
            if (pulses() !== 4'b0000) begin
                n_fail++;
                $display("FAIL no_timeout_cycle%0d: got %b want 0000", k, pulses());
            end
        end
        for (int i = 2; i < f.size(); i++) send_byte(f[i]);
`endif
        ep = model_apply(f);
        n_cmp++;
        if (pulses() !== ep || rx_address !== exp_addr || rx_data !== exp_data || rx_len !== exp_len) begin
            n_fail++;
            $display("FAIL timeout_resume: got pulses=%b data=%h want %b %h", pulses(), rx_data, ep, exp_data);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] f[$];
        logic [3:0] ep;
        f = {8'h8F, 8'h05, 8'h02, 8'hAA, 8'h55};
        foreach (f[i]) send_byte(f[i]);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        exp_addr = '0;
        exp_data = '0;
        exp_len  = 8'd0;
        exp_err  = 0;
        n_cmp++;
        if ({rx_address, rx_data, rx_len, rx_err_count} !== '0 || pulses() !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_mid: got addr=%h data=%h len=%h cnt=%h pulses=%b want all 0",
                     rx_address, rx_data, rx_len, rx_err_count, pulses());
        end
        f = {8'h8F, 8'h7E, 8'h03, 8'h01, 8'h02, 8'h03};
        f.push_back(ref_crc(f));
        send_frame(f, 1);
        ep = model_apply(f);
        n_cmp++;
        if (pulses() !== ep || rx_data !== 80'h010203 || rx_address !== 7'h7E) begin
            n_fail++;
            $display("FAIL reset_then_good: got pulses=%b data=%h addr=%h want %b 010203 7e",
                     pulses(), rx_data, rx_address, ep);
        end
    endtask

    task automatic test_err_saturation();
        logic [7:0] f[$];
        logic [3:0] ep;
        for (int n = 0; n < 300; n++) begin
            make_frame(8'h01, 8'h01, 1, f);
            send_frame(f, 0);
            ep = model_apply(f);
            if (n == 299) begin
                n_cmp++;
                if (pulses() !== ep) begin
                    n_fail++;
                    $display("FAIL sat_last_pulse: got %b want %b", pulses(), ep);
                end
            end
        end
        n_cmp++;
        if (rx_err_count !== 8'(exp_err) || rx_err_count !== 8'd255) begin
            n_fail++;
            $display("FAIL err_saturation: got %0d want 255 (model %0d)", rx_err_count, exp_err);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_good_frame();
        test_crc_error();
        test_len_error();
        test_random();
        test_disable();
        test_timeout();
        test_reset_mid_frame();
        test_err_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
